// File: rtl/jk_cmd_pkg.sv
// Shared definitions for the JK command sequencer: command encodings, the
// sequencer state type and the two helpers that turn a command into J/K
// levels and into the q value the flip-flop should show afterwards.
package jk_cmd_pkg;

  localparam logic [1:0] CMD_HOLD   = 2'b00;
  localparam logic [1:0] CMD_RESET  = 2'b01;
  localparam logic [1:0] CMD_SET    = 2'b10;
  localparam logic [1:0] CMD_TOGGLE = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

  // {j,k} levels that make the flip-flop carry out a command.
  function automatic logic [1:0] cmd_to_jk(input logic [1:0] c);
    logic [1:0] jk;
    case (c)
      CMD_HOLD:   jk = 2'b00;
      CMD_RESET:  jk = 2'b01;
      CMD_SET:    jk = 2'b10;
      CMD_TOGGLE: jk = 2'b11;
      default:    jk = 2'b00;
    endcase
    return jk;
  endfunction

  // q the flip-flop should present once it has applied command c from state q.
  function automatic logic expected_q(input logic [1:0] c, input logic q);
    logic nq;
    case (c)
      CMD_HOLD:   nq = q;
      CMD_RESET:  nq = 1'b0;
      CMD_SET:    nq = 1'b1;
      CMD_TOGGLE: nq = ~q;
      default:    nq = q;
    endcase
    return nq;
  endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// Command FIFO for the JK sequencer. First-word-fall-through: dout shows the
// head entry whenever empty is low. Pointers wrap modulo DEPTH (DEPTH must be
// a power of two, at least 2); a separate occupancy count tells full from
// empty. A push while full and a pop while empty are ignored.
module jk_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage array; no reset needed since dout is only meaningful when !empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; push and pop together leave count alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/jk_cmd_sequencer.sv
// Upstream driver for a JK flip-flop stage. Commands arrive over a
// valid/ready handshake, queue in a small FIFO and are issued one J/K pair
// at a time as registered outputs.
//
// Optional feature, macro JK_CMD_SEQUENCER_CHECK_EN:
//   defined   - each command is followed by a CHECK cycle that compares the
//               flip-flop's q against the predicted value, pulses mismatch
//               and counts mismatches in a saturating err_cnt (2 cycles per
//               command).
//   undefined - no CHECK cycle; commands issue back to back at 1 per cycle,
//               mismatch and err_cnt are tied to 0.
//
// state | meaning
// IDLE  | nothing in flight, j/k at 00, waiting for the FIFO to fill
// DRIVE | j/k carry the current command; flip-flop samples on leaving
// CHECK | j/k back at 00; q_in compared with the predicted q
module jk_cmd_sequencer
  import jk_cmd_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       cmd,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             q_in,
  output logic             j,
  output logic             k,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_cnt
);

  state_t     state;
  state_t     state_nxt;

  logic       fifo_push;
  logic       fifo_pop;
  logic       fifo_full;
  logic       fifo_empty;
  logic [1:0] fifo_dout;

  logic [1:0] jk_nxt;
  logic       done_nxt;

  // Ready depends only on occupancy so upstream may wait on it before valid.
  assign cmd_ready = !fifo_full;
  assign fifo_push = cmd_valid && !fifo_full;
  assign busy      = (state != IDLE) || !fifo_empty;

  jk_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (2)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (cmd),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: leave IDLE on any queued command, chain while work remains.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          state_nxt = DRIVE;
        end
      end
`ifdef JK_CMD_SEQUENCER_CHECK_EN
      DRIVE: begin
        state_nxt = CHECK;
      end
      CHECK: begin
        state_nxt = fifo_empty ? IDLE : DRIVE;
      end
`else
      DRIVE: begin
        state_nxt = fifo_empty ? IDLE : DRIVE;
      end
`endif
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output logic: FIFO pop, next J/K levels and the retire strobe.
  always_comb begin
    fifo_pop = 1'b0;
    jk_nxt   = 2'b00;
    done_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          jk_nxt   = cmd_to_jk(fifo_dout);
        end
      end
`ifdef JK_CMD_SEQUENCER_CHECK_EN
      DRIVE: begin
        jk_nxt = 2'b00;
      end
      CHECK: begin
        done_nxt = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          jk_nxt   = cmd_to_jk(fifo_dout);
        end
      end
`else
      DRIVE: begin
        done_nxt = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          jk_nxt   = cmd_to_jk(fifo_dout);
        end
      end
`endif
      default: begin
        fifo_pop = 1'b0;
      end
    endcase
  end

  // Registered J/K and done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      j    <= 1'b0;
      k    <= 1'b0;
      done <= 1'b0;
    end else begin
      j    <= jk_nxt[1];
      k    <= jk_nxt[0];
      done <= done_nxt;
    end
  end

`ifdef JK_CMD_SEQUENCER_CHECK_EN
  localparam logic [ERR_W-1:0] ERR_MAX = '1;
  localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);

  logic [1:0]       cur_cmd;
  logic             exp_q;
  logic             mm_nxt;
  logic [ERR_W-1:0] err_q;

  // Remember which command is on j/k so the prediction can be formed in DRIVE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_cmd <= CMD_HOLD;
    end else if (fifo_pop) begin
      cur_cmd <= fifo_dout;
    end
  end

  // Predict q from the q present while the flip-flop samples j/k.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q <= 1'b0;
    end else if (state == DRIVE) begin
      exp_q <= expected_q(cur_cmd, q_in);
    end
  end

  // Compare in CHECK; written as if/else so an unknown q_in lands on mismatch.
  always_comb begin
    mm_nxt = 1'b0;
    if (state == CHECK) begin
      if (q_in == exp_q) begin
        mm_nxt = 1'b0;
      end else begin
        mm_nxt = 1'b1;
      end
    end
  end

  // Mismatch pulse and saturating error counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mismatch <= 1'b0;
      err_q    <= '0;
    end else begin
      mismatch <= mm_nxt;
      if (mm_nxt && (err_q != ERR_MAX)) begin
        err_q <= err_q + ERR_ONE;
      end
    end
  end

  assign err_cnt = err_q;
`else
  // Without checking, q_in has no consumer.
  logic unused_q_in;
  assign unused_q_in = q_in;
  assign mismatch    = 1'b0;
  assign err_cnt     = '0;
`endif

endmodule
